// File: rtl/pps_mem_pkg.sv
// Shared definitions for the PPS SRAM front ends:
// state encoding, the default bubble instruction and the external SRAM data width.
package pps_mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_VALID = 3'd3,
        S_LATCH = 3'd4
    } mem_state_e;

    localparam int          SRAM_DW      = 16;
    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

endpackage

// File: rtl/pps_wait_cnt.sv
// Loadable down-counter with a terminal-count flag that paces SRAM wait states.
// When the counter is at zero and enabled, it holds at zero.
module pps_wait_cnt #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          en_i,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Load takes priority over counting down.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != {CW{1'b0}})) begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/pps_imem_sram_ctrl.sv
// Instruction fetch front end: reads each 32-bit instruction as two half-words from
// an asynchronous 16-bit SRAM and holds the fetch PC until the word is ready.
module pps_imem_sram_ctrl
    import pps_mem_pkg::*;
#(
    parameter int          ADDR_W   = 18,
    parameter int          WAIT_CYC = 2,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc_in,
    input  logic               stomp,
    output logic [31:0]        inst_out,
    output logic               inst_valid,
    output logic               stall,
    output logic [ADDR_W-1:0]  sram_addr,
    input  logic [SRAM_DW-1:0] sram_dq,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int          CW      = 4;
    localparam logic [CW-1:0] WAIT_LD = CW'(WAIT_CYC - 1);

    mem_state_e           state_q, state_d;
    logic [ADDR_W-2:0]    addr_q, addr_d;
    logic [SRAM_DW-1:0]   lo_q, lo_d;
    logic [31:0]          word_q, word_d;
    logic                 cnt_load_s;
    logic [CW-1:0]        cnt_val_s;
    logic                 cnt_en_s;
    logic                 cnt_tc_s;
    logic                 unused_pc_s;

    pps_wait_cnt #(.CW(CW)) u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_val_s),
        .en_i       (cnt_en_s),
        .tc_o       (cnt_tc_s)
    );

    // Next-state logic: sequencing of the two half-word reads and redirect aborts.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        lo_d       = lo_q;
        word_d     = word_q;
        cnt_load_s = 1'b0;
        cnt_val_s  = WAIT_LD;
        cnt_en_s   = 1'b0;
        case (state_q)
            S_IDLE, S_LATCH: begin
                addr_d     = pc_in[ADDR_W:2];
                cnt_load_s = 1'b1;
                state_d    = S_RD_LO;
            end
            S_RD_LO: begin
                if (stomp) begin
                    lo_d       = {SRAM_DW{1'b0}};
                    cnt_load_s = 1'b1;
                    cnt_val_s  = {CW{1'b0}};
                    state_d    = S_LATCH;
                end else if (cnt_tc_s) begin
                    lo_d       = sram_dq;
                    cnt_load_s = 1'b1;
                    state_d    = S_RD_HI;
                end else begin
                    cnt_en_s   = 1'b1;
                end
            end
            S_RD_HI: begin
                // A redirect on the final wait cycle still wins over delivery.
                if (stomp) begin
                    lo_d       = {SRAM_DW{1'b0}};
                    cnt_load_s = 1'b1;
                    cnt_val_s  = {CW{1'b0}};
                    state_d    = S_LATCH;
                end else if (cnt_tc_s) begin
                    word_d     = {sram_dq, lo_q};
                    cnt_load_s = 1'b1;
                    cnt_val_s  = {CW{1'b0}};
                    state_d    = S_VALID;
                end else begin
                    cnt_en_s   = 1'b1;
                end
            end
            S_VALID: begin
                state_d = S_LATCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= {(ADDR_W-1){1'b0}};
            lo_q    <= {SRAM_DW{1'b0}};
            word_q  <= NOP_WORD;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            word_q  <= word_d;
        end
    end

    assign inst_valid = (state_q == S_VALID);
    assign inst_out   = (state_q == S_VALID) ? word_q : NOP_WORD;
    assign stall      = (state_q != S_VALID);
    assign sram_ce_n  = !((state_q == S_RD_LO) || (state_q == S_RD_HI));
    assign sram_oe_n  = sram_ce_n;
    assign sram_ub_n  = sram_ce_n;
    assign sram_lb_n  = sram_ce_n;
    assign sram_we_n  = 1'b1;
    assign sram_addr  = {addr_q, (state_q == S_RD_HI)};

    assign unused_pc_s = ^{pc_in[31:ADDR_W+1], pc_in[1:0]};

endmodule
